// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory-wait timeout,
// sticky fault flags and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        memToReg,
  output logic        aluSrcA,
  output logic        regWrite,
  output logic        regDst,
  output logic [1:0]  pcSource,
  output logic [1:0]  aluOp,
  output logic [1:0]  aluSrcB,
  output logic [3:0]  state,
  output logic        halted,
  output logic        busErr,
  output logic        illegalOp,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BEQ       = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [7:0] W_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic        r_busErr;
  logic        r_illegal;
  logic [31:0] r_retired;
  logic        w_tout;
  logic        w_tmo;
  logic        w_ill;
  logic        w_retire;
  logic        w_wait_st;

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_READ)
                  || (r_state == S_MEM_WRITE);
  // memReady in the expiring cycle still wins over the timeout
  assign w_tout = !memReady && (r_wait == W_LAST);

  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    w_ill  = 1'b0;
    unique case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: begin
        if (memReady) w_next = S_DECODE;
        else if (w_tout) begin
          w_next = S_HALT;
          w_tmo  = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_R:          w_next = S_R_EXEC;
          OP_LW, OP_SW:  w_next = S_MEM_ADDR;
          OP_BEQ:        w_next = S_BEQ;
          OP_ADDI:       w_next = S_ADDI_EXEC;
          OP_J:          w_next = S_JUMP;
          default: begin
            w_next = S_HALT;
            w_ill  = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) w_next = S_MEM_READ;
        else if (opcode == OP_SW) w_next = S_MEM_WRITE;
        else begin
          w_next = S_HALT;
          w_ill  = 1'b1;
        end
      end
      S_MEM_READ, S_MEM_WRITE: begin
        if (memReady) begin
          w_next = (r_state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        end else if (w_tout) begin
          w_next = S_HALT;
          w_tmo  = 1'b1;
        end
      end
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BEQ, S_JUMP:
        w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_HALT;
    endcase
  end

  assign w_retire = (r_state == S_MEM_WB) || (r_state == S_R_WB)
                 || (r_state == S_ADDI_WB) || (r_state == S_BEQ)
                 || (r_state == S_JUMP)
                 || ((r_state == S_MEM_WRITE) && memReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_wait    <= '0;
      r_busErr  <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= '0;
      else if (w_wait_st && !memReady) r_wait <= r_wait + 8'd1;
      if (w_tmo) r_busErr <= 1'b1;
      if (w_ill) r_illegal <= 1'b1;
      if (w_retire) r_retired <= r_retired + 32'd1;
    end
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    pcSource    = 2'b00;
    aluOp       = 2'b00;
    aluSrcB     = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        pcWrite = memReady;
        irWrite = memReady;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      S_R_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      S_R_WB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_BEQ: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      S_ADDI_WB: regWrite = 1'b1;
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign state     = r_state;
  assign halted    = (r_state == S_HALT);
  assign busErr    = r_busErr;
  assign illegalOp = r_illegal;
  assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction state plans built
// from opcode class and memory latencies, checked every cycle.
module tb_multicycle_control;

  localparam int TO = 16;

  localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2;
  localparam int ST_MADDR = 3, ST_MREAD = 4, ST_MWB = 5;
  localparam int ST_MWRITE = 6, ST_REXEC = 7, ST_RWB = 8;
  localparam int ST_BEQ = 9, ST_AEXEC = 10, ST_AWB = 11;
  localparam int ST_JUMP = 12, ST_HALT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic        memReady = 1'b0;
  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite;
  logic        irWrite, memToReg, aluSrcA, regWrite, regDst;
  logic [1:0]  pcSource, aluOp, aluSrcB;
  logic [3:0]  state;
  logic        halted, busErr, illegalOp;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  int unsigned ret_m = 0;
  logic        bus_m = 1'b0;
  logic        ill_m = 1'b0;

  multicycle_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .aluSrcA(aluSrcA), .regWrite(regWrite),
    .regDst(regDst), .pcSource(pcSource), .aluOp(aluOp),
    .aluSrcB(aluSrcB), .state(state), .halted(halted),
    .busErr(busErr), .illegalOp(illegalOp), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,
  //  aluSrcA,regWrite,regDst,pcSource,aluOp,aluSrcB,halted}
  function automatic logic [16:0] exp_out(input int s, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, asa, rw, rd, hl;
    logic [1:0] ps, ao, asb;
    {pw, pwc, iod, mrd, mwr, irw, m2r, asa, rw, rd, hl} = '0;
    ps = 2'b00; ao = 2'b00; asb = 2'b00;
    case (s)
      ST_FETCH:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
      ST_DECODE: asb = 2'b11;
      ST_MADDR, ST_AEXEC: begin asa = 1; asb = 2'b10; end
      ST_MREAD:  begin mrd = 1; iod = 1; end
      ST_MWB:    begin rw = 1; m2r = 1; end
      ST_MWRITE: begin mwr = 1; iod = 1; end
      ST_REXEC:  begin asa = 1; ao = 2'b10; end
      ST_RWB:    begin rw = 1; rd = 1; end
      ST_BEQ:    begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      ST_AWB:    rw = 1;
      ST_JUMP:   begin pw = 1; ps = 2'b10; end
      ST_HALT:   hl = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, asa, rw, rd,
            ps, ao, asb, hl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input int s);
    chk("state", 32'(state), 32'(s));
    chk("outputs", 32'({pcWrite, pcWriteCond, iorD, memRead, memWrite,
        irWrite, memToReg, aluSrcA, regWrite, regDst, pcSource, aluOp,
        aluSrcB, halted}), 32'(exp_out(s, memReady)));
    chk("retired", retired, ret_m);
    chk("busErr", 32'(busErr), 32'(bus_m));
    chk("illegalOp", 32'(illegalOp), 32'(ill_m));
  endtask

  task automatic cyc(input int s, input logic mr);
    @(negedge clk);
    memReady = mr;
    #1;
    check_all(s);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // n cycles of memReady=0 then one with memReady=1, unless the
  // TO-th consecutive stall arrives first (then h=1)
  task automatic wait_phase(input int s, input int n, output bit h);
    h = 0;
    for (int i = 0; i <= n; i++) begin
      cyc(s, (i == n));
      if (i != n && i + 1 == TO) begin
        h = 1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw,
                           input int mw);
    bit h;
    opcode = op;
    wait_phase(ST_FETCH, fw, h);
    if (h) begin bus_m = 1; return; end
    cyc(ST_DECODE, rnd());
    case (op)
      6'b000000: begin
        cyc(ST_REXEC, rnd()); cyc(ST_RWB, rnd()); ret_m++;
      end
      6'b100011: begin
        cyc(ST_MADDR, rnd());
        wait_phase(ST_MREAD, mw, h);
        if (h) bus_m = 1;
        else begin cyc(ST_MWB, rnd()); ret_m++; end
      end
      6'b101011: begin
        cyc(ST_MADDR, rnd());
        wait_phase(ST_MWRITE, mw, h);
        if (h) bus_m = 1;
        else ret_m++;
      end
      6'b000100: begin cyc(ST_BEQ, rnd()); ret_m++; end
      6'b001000: begin
        cyc(ST_AEXEC, rnd()); cyc(ST_AWB, rnd()); ret_m++;
      end
      6'b000010: begin cyc(ST_JUMP, rnd()); ret_m++; end
      default: ill_m = 1;
    endcase
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom);
      cyc(ST_HALT, rnd());
    end
  endtask

  // asserted mid-cycle, released after a clock edge has passed
  task automatic rst_async();
    rst_n = 1'b0;
    ret_m = 0; bus_m = 0; ill_m = 0;
    #1;
    check_all(ST_RST);
    @(negedge clk);
    check_all(ST_RST);
    rst_n = 1'b1;
    #1;
    check_all(ST_RST);
  endtask

  logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b001000, 6'b000010};

  initial begin
    #2;
    rst_async();

    run_instr(6'b000000, 0, 0);
    for (int k = 0; k < 40; k++) begin
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                $urandom_range(0, 5));
    end

    run_instr(6'b100011, 0, 3);
    run_instr(6'b000000, TO - 1, 0);
    run_instr(6'b100011, 1, TO - 1);
    run_instr(6'b101011, 0, TO - 1);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001000, 2, 0);

    run_instr(6'b101011, 0, TO);
    hold_halt(10);
    rst_async();

    run_instr(6'b000100, 0, 0);
    run_instr(6'b111111, 0, 0);
    hold_halt(10);
    rst_async();

    run_instr(6'b000000, TO, 0);
    hold_halt(10);
    rst_async();

    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    cyc(ST_FETCH, 1'b0);
    rst_async();

    opcode = 6'b101011;
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, 1'b0);
    cyc(ST_MADDR, 1'b0);
    cyc(ST_MWRITE, 1'b0);
    cyc(ST_MWRITE, 1'b0);
    rst_async();
    run_instr(6'b000000, 0, 0);
    cyc(ST_FETCH, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
